// File: rtl/mux_n_1_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_n_1_pipe_if
//
// Purpose
//   Bundles the request side (producer -> select block) and the response side
//   (select block -> consumer) of mux_n_1_pipe into one interface.
//
// Parameters
//   WIDTH  data word width in bits
//   N      number of input words (2..16)
//   SEL_W  select width, derived from N; leave at its default
//
// Signals
//   in_valid   producer presents a select request
//   in_ready   block can accept a request this cycle
//   in_sel     index of the word to select
//   in_data    flattened words; word i = in_data[i*WIDTH +: WIDTH]
//   out_valid  head entry valid
//   out_ready  consumer accepts head entry
//   out_data   selected word of the head entry
//   out_sel    select that produced out_data
//   out_err    head entry came from an illegal select
//
// Modports
//   master  environment view: drives requests and out_ready
//   slave   block view: drives in_ready and the head entry
// -----------------------------------------------------------------------------
interface mux_n_1_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [N*WIDTH-1:0]   in_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_err;

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        output out_err
    );
endinterface : mux_n_1_pipe_if

// File: rtl/mux_n_1_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_1_pipe
//
// Purpose
//   N:1 word select with a registered, 2-entry buffered valid/ready output.
//   The producer presents N words and a select; the chosen word is latched
//   together with its select and an illegal-select flag, and handed
//   downstream under backpressure. Illegal selects (in_sel >= N, only
//   reachable when N is not a power of two) store a zero word with the error
//   flag set and bump a saturating counter, so no garbage ever reaches the
//   consumer.
//
// Parameters
//   WIDTH  data word width in bits                       (default 32)
//   N      number of input words, legal range 2..16     (default 4)
//   ERR_W  width of the saturating illegal-select count  (default 8)
//   SEL_W  derived select width, $clog2(N)
//
// Ports
//   clk      single clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   bus      mux_n_1_pipe_if slave modport (request + response handshakes)
//   err_cnt  saturating count of accepted illegal selects
//
// Timing
//   A request accepted on edge t is visible on out_* right after that edge
//   (one-cycle latency, no bypass). With out_ready held high the block
//   sustains one word per cycle. in_ready depends only on registered state.
// -----------------------------------------------------------------------------
module mux_n_1_pipe #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int ERR_W = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_n_1_pipe_if.slave    bus,
    output logic [ERR_W-1:0] err_cnt
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------

    // One buffered entry: the word, the select that produced it and
    // whether that select was out of range.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } entry_t;

    // N widened by one bit so the range compare also works when N is a
    // power of two (N itself does not fit in SEL_W bits then).
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(N);

    localparam logic [1:0]       CNT_EMPTY = 2'd0;
    localparam logic [1:0]       CNT_FULL  = 2'd2;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    entry_t           mem [2];      // storage, indexed by head/tail
    logic [1:0]       count;        // occupancy, 0..2
    logic             head;         // entry shown on out_*
    logic             tail;         // entry written by the next push

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic             sel_legal;
    logic [WIDTH-1:0] sel_word;
    entry_t           wr_entry;
    entry_t           head_entry;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign full  = (count == CNT_FULL);
    assign empty = (count == CNT_EMPTY);

    // in_ready comes from the occupancy register alone; a pop in the same
    // cycle does not free a slot for a push while full.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    // ------------------------------------------------------------------
    // Word select
    // ------------------------------------------------------------------
    assign sel_legal = ({1'b0, bus.in_sel} < SEL_LIMIT);

    // The loop only visits legal indices, so an out-of-range select never
    // matches and leaves the word at zero.
    always_comb begin
        // NOTE: default first so every path assigns sel_word; without it
        // the tool infers a latch to hold the previous value.
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                sel_word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        wr_entry.data = sel_legal ? sel_word : '0;
        wr_entry.sel  = bus.in_sel;
        wr_entry.err  = !sel_legal;
    end

    // ------------------------------------------------------------------
    // Occupancy and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all registered state so
            // every flop samples pre-edge values regardless of block order.
            count <= CNT_EMPTY;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            // 1-bit pointers wrap 1 -> 0 by simply toggling.
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;

            // push & pop together leaves the count unchanged.
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: storage has no reset; stale contents are never observable
    // because the output is masked while empty and a slot is always
    // written before the head pointer can reach it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Illegal-select counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (push && wr_entry.err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Head entry to the consumer
    // ------------------------------------------------------------------
    // Masked to zero while empty so the consumer never sees stale storage.
    assign head_entry   = empty ? '0 : mem[head];
    assign bus.out_data = head_entry.data;
    assign bus.out_sel  = head_entry.sel;
    assign bus.out_err  = head_entry.err;

    // ------------------------------------------------------------------
    // Properties
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    // Occupancy never leaves 0..2.
    a_count_range : assert property (
        @(posedge clk) disable iff (!rst_n)
        count <= CNT_FULL
    );

    // A stalled head entry stays valid and unchanged until taken.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) &&
             $stable(bus.out_sel) && $stable(bus.out_err))
    );

    // No accepted request while the buffer is full.
    a_no_push_full : assert property (
        @(posedge clk) disable iff (!rst_n)
        full |-> !push
    );
`endif

endmodule : mux_n_1_pipe
